// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: sync, polarity, symmetric debounce,
// press/release pulses, long-press detection and optional auto-repeat.
module button_conditioner #(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int LONG_CYCLES     = 100000000,
  parameter int REPEAT_CYCLES   = 25000000,
  parameter int ACTIVE_LOW_IN   = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] btn_in,
  output logic [NUM_CH-1:0] btn_level,
  output logic [NUM_CH-1:0] press_pulse,
  output logic [NUM_CH-1:0] release_pulse,
  output logic [NUM_CH-1:0] long_pulse,
  output logic [NUM_CH-1:0] repeat_pulse
);

  localparam int DW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HW       = $clog2(HOLD_MAX) + 1;

  localparam logic [DW-1:0]     DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0]     LONG_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0]     REP_LAST  = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam bit                REPEAT_EN = (REPEAT_CYCLES > 0);
  localparam logic [NUM_CH-1:0] POL_MASK  = {NUM_CH{ACTIVE_LOW_IN != 0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } hold_state_e;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic          meta_q;
    logic          sync_q;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          level_q, level_d;
    logic          press_q, release_q, long_q, repeat_q;
    logic          long_d, repeat_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    hold_state_e   state_q, state_d;
    logic          press_acc, release_acc;

    // Debounce: the synchronised sample must disagree with the accepted
    // level for DEBOUNCE_CYCLES consecutive clocks before it is adopted.
    always_comb begin
      dcnt_d      = dcnt_q;
      level_d     = level_q;
      press_acc   = 1'b0;
      release_acc = 1'b0;
      if (sync_q == level_q) begin
        dcnt_d = '0;
      end else if (dcnt_q == DEB_LAST) begin
        dcnt_d      = '0;
        level_d     = sync_q;
        press_acc   = sync_q;
        release_acc = ~sync_q;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end

    // Hold tracking; a release accepted this cycle wins over a due long/repeat.
    always_comb begin
      state_d  = state_q;
      hcnt_d   = hcnt_q;
      long_d   = 1'b0;
      repeat_d = 1'b0;
      if (press_acc) begin
        state_d = HELD;
        hcnt_d  = '0;
      end else if (release_acc || !level_q) begin
        state_d = IDLE;
        hcnt_d  = '0;
      end else begin
        case (state_q)
          HELD: begin
            if (hcnt_q == LONG_LAST) begin
              state_d = LONG;
              hcnt_d  = '0;
              long_d  = 1'b1;
            end else begin
              hcnt_d = hcnt_q + 1'b1;
            end
          end
          LONG: begin
            if (REPEAT_EN && (hcnt_q == REP_LAST)) begin
              hcnt_d   = '0;
              repeat_d = 1'b1;
            end else if (hcnt_q != '1) begin
              hcnt_d = hcnt_q + 1'b1;
            end
          end
          default: begin
            state_d = IDLE;
            hcnt_d  = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        meta_q    <= 1'b0;
        sync_q    <= 1'b0;
        dcnt_q    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
        hcnt_q    <= '0;
        state_q   <= IDLE;
      end else begin
        meta_q    <= btn_in[ch] ^ POL_MASK[ch];
        sync_q    <= meta_q;
        dcnt_q    <= dcnt_d;
        level_q   <= level_d;
        press_q   <= press_acc;
        release_q <= release_acc;
        long_q    <= long_d;
        repeat_q  <= repeat_d;
        hcnt_q    <= hcnt_d;
        state_q   <= state_d;
      end
    end

    assign btn_level[ch]     = level_q;
    assign press_pulse[ch]   = press_q;
    assign release_pulse[ch] = release_q;
    assign long_pulse[ch]    = long_q;
    assign repeat_pulse[ch]  = repeat_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: dutA is active-high with repeats,
// dutB is active-low with repeats disabled. Outputs sampled on negedge.
module tb_button_conditioner;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] btnA, btnB;
  logic [1:0] levelA, pressA, releaseA, longA, repeatA;
  logic [1:0] levelB, pressB, releaseB, longB, repeatB;
  int         testCount = 0;
  int         failCount = 0;

  always #5 clock = ~clock;

  button_conditioner #(
    .NUM_CH(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(5), .ACTIVE_LOW_IN(0)
  ) dutA (
    .clock(clock), .reset(reset), .btn_in(btnA), .btn_level(levelA),
    .press_pulse(pressA), .release_pulse(releaseA), .long_pulse(longA), .repeat_pulse(repeatA)
  );

  button_conditioner #(
    .NUM_CH(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(0), .ACTIVE_LOW_IN(1)
  ) dutB (
    .clock(clock), .reset(reset), .btn_in(btnB), .btn_level(levelB),
    .press_pulse(pressB), .release_pulse(releaseB), .long_pulse(longB), .repeat_pulse(repeatB)
  );

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      testCount++;
      if ({levelA, pressA, releaseA, longA, repeatA} !== 10'b0) begin
        failCount++;
        $display("[TB] FAIL reset_A got %b want %b", {levelA, pressA, releaseA, longA, repeatA}, 10'b0);
      end
      testCount++;
      if ({levelB, pressB, releaseB, longB, repeatB} !== 10'b0) begin
        failCount++;
        $display("[TB] FAIL reset_B got %b want %b", {levelB, pressB, releaseB, longB, repeatB}, 10'b0);
      end
    end
    reset = 1'b1;
  endtask

  // Fields in each compare: {level, press, release, long, repeat}, 2 bits each.
  task automatic test_clean_press_long_repeat();
    logic [9:0] expOut;
    btnA = 2'b01;
    for (int k = 1; k <= 52; k++) begin
      @(negedge clock);
      expOut = {1'b0, (k >= 6 && k < 48), 1'b0, (k == 6), 1'b0, (k == 48), 1'b0, (k == 26),
                1'b0, (k == 31 || k == 36 || k == 41 || k == 46)};
      testCount++;
      if ({levelA, pressA, releaseA, longA, repeatA} !== expOut) begin
        failCount++;
        $display("[TB] FAIL clean_press k=%0d got %b want %b", k, {levelA, pressA, releaseA, longA, repeatA}, expOut);
      end
      if (k == 42) btnA = 2'b00;
    end
  endtask

  task automatic test_glitch_reject();
    for (int k = 0; k < 30; k++) begin
      btnA = {(k < 20) && ((k % 4) != 3), 1'b0};
      @(negedge clock);
      testCount++;
      if ({levelA, pressA, releaseA} !== 6'b0) begin
        failCount++;
        $display("[TB] FAIL glitch k=%0d got %b want %b", k, {levelA, pressA, releaseA}, 6'b0);
      end
    end
  endtask

  task automatic test_release();
    logic [9:0] expOut;
    btnA = 2'b01;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clock);
      expOut = {1'b0, (k >= 6 && k < 16), 1'b0, (k == 6), 1'b0, (k == 16), 4'b0};
      testCount++;
      if ({levelA, pressA, releaseA, longA, repeatA} !== expOut) begin
        failCount++;
        $display("[TB] FAIL release k=%0d got %b want %b", k, {levelA, pressA, releaseA, longA, repeatA}, expOut);
      end
      if (k == 10) btnA = 2'b00;
    end
  endtask

  // Release reaches btn_level on the same edge the long pulse would be issued.
  task automatic test_release_race_long();
    logic [9:0] expOut;
    btnA = 2'b01;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clock);
      expOut = {1'b0, (k >= 6 && k < 26), 1'b0, (k == 6), 1'b0, (k == 26), 4'b0};
      testCount++;
      if ({levelA, pressA, releaseA, longA, repeatA} !== expOut) begin
        failCount++;
        $display("[TB] FAIL release_race k=%0d got %b want %b", k, {levelA, pressA, releaseA, longA, repeatA}, expOut);
      end
      if (k == 20) btnA = 2'b00;
    end
  endtask

  task automatic test_polarity_no_repeat();
    logic [9:0] expOut;
    btnB = 2'b10;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clock);
      expOut = {1'b0, (k >= 6 && k < 66), 1'b0, (k == 6), 1'b0, (k == 66), 1'b0, (k == 26), 2'b0};
      testCount++;
      if ({levelB, pressB, releaseB, longB, repeatB} !== expOut) begin
        failCount++;
        $display("[TB] FAIL polarity k=%0d got %b want %b", k, {levelB, pressB, releaseB, longB, repeatB}, expOut);
      end
      if (k == 60) btnB = 2'b11;
    end
  endtask

  task automatic test_async_reset_mid_hold();
    logic [9:0] expOut;
    btnA = 2'b01;
    for (int k = 1; k <= 15; k++) @(negedge clock);
    testCount++;
    if (levelA !== 2'b01) begin
      failCount++;
      $display("[TB] FAIL pre_reset_level got %b want %b", levelA, 2'b01);
    end
    reset = 1'b0;
    #1;
    testCount++;
    if ({levelA, pressA, releaseA, longA, repeatA} !== 10'b0) begin
      failCount++;
      $display("[TB] FAIL async_reset_immediate got %b want %b", {levelA, pressA, releaseA, longA, repeatA}, 10'b0);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      testCount++;
      if ({levelA, pressA, releaseA, longA, repeatA} !== 10'b0) begin
        failCount++;
        $display("[TB] FAIL async_reset_hold k=%0d got %b want %b", k, {levelA, pressA, releaseA, longA, repeatA}, 10'b0);
      end
    end
    reset = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      expOut = {1'b0, (k >= 6), 1'b0, (k == 6), 6'b0};
      testCount++;
      if ({levelA, pressA, releaseA, longA, repeatA} !== expOut) begin
        failCount++;
        $display("[TB] FAIL after_reset k=%0d got %b want %b", k, {levelA, pressA, releaseA, longA, repeatA}, expOut);
      end
    end
    btnA = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      expOut = {1'b0, (k < 6), 1'b0, 1'b0, 1'b0, (k == 6), 4'b0};
      testCount++;
      if ({levelA, pressA, releaseA, longA, repeatA} !== expOut) begin
        failCount++;
        $display("[TB] FAIL after_reset_release k=%0d got %b want %b", k, {levelA, pressA, releaseA, longA, repeatA}, expOut);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    btnA  = 2'b00;
    btnB  = 2'b11;
    test_reset();
    test_clean_press_long_repeat();
    test_glitch_reject();
    test_release();
    test_release_race_long();
    test_polarity_no_repeat();
    test_async_reset_mid_hold();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Parametrised, multi-channel successor to the single-button debouncer; conditions NUM_CH raw push-button or switch inputs in the 100 MHz clock domain.
- Per channel it provides:
  - two-flop synchronisation
  - selectable input polarity
  - symmetric press/release debounce
  - a clean debounced level
  - one-cycle press and release pulses
  - long-press detection
  - optional auto-repeat while held
- Sits between the board pins and the game/UI control FSMs; replaces per-button debouncer instances.

Parameters:
- NUM_CH, 4, number of independent input channels (1..16).
- DEBOUNCE_CYCLES, 2000000, consecutive stable synchronised samples required to accept a level change (>=2).
- LONG_CYCLES, 100000000, cycles a debounced press must be held before long_pulse fires (> DEBOUNCE_CYCLES).
- REPEAT_CYCLES, 25000000, auto-repeat period after long press; 0 disables auto-repeat.
- ACTIVE_LOW_IN, 0, 1 = raw inputs are pressed-when-0 (inverted before synchronisers).

Ports:
- clock, input, 1, system clock (100 MHz).
- reset, input, 1, asynchronous, active-low reset.
- btn_in, input, NUM_CH, raw asynchronous button inputs.
- btn_level, output, NUM_CH, debounced level (1 = pressed).
- press_pulse, output, NUM_CH, one-cycle pulse on accepted press.
- release_pulse, output, NUM_CH, one-cycle pulse on accepted release.
- long_pulse, output, NUM_CH, one-cycle pulse when hold reaches LONG_CYCLES.
- repeat_pulse, output, NUM_CH, one-cycle pulse every REPEAT_CYCLES after long_pulse while held.

Behaviour:
- Reset is asynchronous and active-low. It clears all synchronisers, counters, btn_level and all pulse outputs to 0. A reset mid-press yields btn_level=0; a still-held button then re-debounces as a fresh press after reset deassertion, with no release pulse emitted.
- Channels are fully independent; no shared counters; identical logic per channel.
- Synchroniser: raw = btn_in[i] XOR ACTIVE_LOW_IN, then 2 flops, giving s.
- Debounce counter dcnt, width $clog2(DEBOUNCE_CYCLES)+1:
  - If s == btn_level: dcnt <= 0.
  - Else if dcnt == DEBOUNCE_CYCLES-1: btn_level <= s, dcnt <= 0.
  - Else dcnt <= dcnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES samples never changes btn_level. The debounce is symmetric for press and release.
- Latency: a clean raw edge reaches s after 2 clocks; btn_level changes DEBOUNCE_CYCLES clocks after s changes.
- press_pulse/release_pulse are registered and high exactly in the first cycle btn_level shows the new value. They are never both high, and there is no pulse without a level change.
- Hold counter hcnt, width sized for max(LONG_CYCLES, REPEAT_CYCLES):
  - Cleared to 0 in the cycle press_pulse is high.
  - Increments each cycle while btn_level=1.
  - Cleared whenever btn_level=0.
- Hold state machine, per channel:
  - IDLE -> HELD on press.
  - HELD -> LONG when hcnt reaches LONG_CYCLES-1: long_pulse high next cycle, i.e. exactly LONG_CYCLES cycles after press_pulse; hcnt restarts at 0.
  - LONG, REPEAT_CYCLES != 0: repeat_pulse every REPEAT_CYCLES cycles, the first one REPEAT_CYCLES cycles after long_pulse.
  - LONG, REPEAT_CYCLES == 0: no repeats.
  - Any state -> IDLE on release, with no further long/repeat pulses. A release accepted in the same cycle a long/repeat would fire suppresses that long/repeat.
- Counters never wrap: hcnt saturates in LONG when repeats are disabled.
- All outputs are registered; no combinational path from btn_in to outputs.

Test Plan (sim params: NUM_CH=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5):
1. Clean press: btn_in[0] 0->1 held 40 cycles -> btn_level[0] rises 6 clocks after the edge (2 sync + 4 debounce), press_pulse[0] high 1 cycle in that same cycle, long_pulse[0] 20 cycles later, repeat_pulse[0] at +5, +10, +15 after long_pulse; channel 1 outputs stay 0.
2. Glitch rejection: 3-cycle high pulses on btn_in[1] separated by 1-cycle lows -> btn_level[1], press_pulse[1] and release_pulse[1] stay 0 throughout.
3. Release: after a 10-cycle held press, btn_in[0] 1->0 -> release_pulse[0] high 1 cycle, btn_level[0] falls 6 clocks after the edge, no long_pulse.
4. Release racing long: release accepted in the cycle hcnt==LONG_CYCLES-1 -> no long_pulse or repeat_pulse; release_pulse asserted.
5. Polarity and repeat disable: rerun with ACTIVE_LOW_IN=1 and REPEAT_CYCLES=0, btn_in idle high, driven low for 60 cycles -> press/long pulses behave as in scenario 1, no repeat_pulse.
6. Async reset mid-hold: assert reset 15 cycles into a held press, release reset while the button is still held -> all outputs 0 immediately; press_pulse re-fires 6 clocks after reset deassertion; no release_pulse.
